// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: request/grant sharing of the SPI pins between flash engine (0) and codec configurator (1), with a guard gap between owners; SPI_ARB_TIMEOUT_EN adds a MAX_HOLD revoke.
module spi_bus_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic        SCK_IDLE     = 1'b0,
  parameter int unsigned MAX_HOLD     = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic rq0_sck,
  input  logic rq0_mosi,
  input  logic rq0_csn,
  input  logic rq1_sck,
  input  logic rq1_mosi,
  input  logic rq1_csn,
  output logic spi_sck,
  output logic spi_mosi,
  output logic flash_csn,
  output logic codec_csn,
  output logic busy,
  output logic timeout
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_t;
  state_t state_q, state_d, arb;
  logic last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic sck_q, sck_d, mosi_q, mosi_d;
  logic fcs_q, fcs_d, ccs_q, ccs_d;
  logic busy_q, busy_d;
  logic el0, el1, rel, to, drop, stay0, stay1;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] hold_q, hold_d;
  logic [1:0] arm_q, arm_d;
  logic timeout_q, timeout_d;
`endif
  always_comb begin
`ifdef SPI_ARB_TIMEOUT_EN
    el0 = req0 & arm_q[0];
    el1 = req1 & arm_q[1];
    to = ((state_q == OWN0) & req0 | (state_q == OWN1) & req1) & (hold_q == 16'(MAX_HOLD - 1));
`else
    el0 = req0;
    el1 = req1;
    to = 1'b0;
`endif
    rel = (state_q == OWN0) & ~req0 | (state_q == OWN1) & ~req1;
    drop = rel | to;
    arb = (el0 & el1) ? (last_q ? OWN0 : OWN1) : el1 ? OWN1 : el0 ? OWN0 : IDLE;
    state_d = (state_q == IDLE || (state_q == GUARD && cnt_q == 8'd0)) ? arb :
              (state_q == GUARD) ? GUARD :
              drop ? ((GUARD_CYCLES == 0) ? IDLE : GUARD) : state_q;
    cnt_d = (state_q == GUARD) ? cnt_q - 8'd1 : 8'(GUARD_CYCLES - 1);
    last_d = drop ? (state_q == OWN1) : last_q;
    stay0 = (state_q == OWN0) && (state_d == OWN0);
    stay1 = (state_q == OWN1) && (state_d == OWN1);
    sck_d = stay0 ? rq0_sck : stay1 ? rq1_sck : SCK_IDLE;
    mosi_d = stay0 ? rq0_mosi : stay1 ? rq1_mosi : 1'b0;
    fcs_d = stay0 ? rq0_csn : 1'b1;
    ccs_d = stay1 ? rq1_csn : 1'b1;
    gnt0_d = (state_d == OWN0);
    gnt1_d = (state_d == OWN1);
    busy_d = (state_d != IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
    hold_d = (stay0 | stay1) ? hold_q + 16'd1 : 16'd0;
    arm_d[0] = ~req0 | (arm_q[0] & ~(to & (state_q == OWN0)));
    arm_d[1] = ~req1 | (arm_q[1] & ~(to & (state_q == OWN1)));
    timeout_d = to;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b0;
      cnt_q <= 8'd0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      sck_q <= SCK_IDLE;
      mosi_q <= 1'b0;
      fcs_q <= 1'b1;
      ccs_q <= 1'b1;
      busy_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_q <= 16'd0;
      arm_q <= 2'b11;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      fcs_q <= fcs_d;
      ccs_q <= ccs_d;
      busy_q <= busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_q <= hold_d;
      arm_q <= arm_d;
      timeout_q <= timeout_d;
`endif
    end
  end
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign spi_sck = sck_q;
  assign spi_mosi = mosi_q;
  assign flash_csn = fcs_q;
  assign codec_csn = ccs_q;
  assign busy = busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed self-checking bench for spi_bus_arbiter (GUARD_CYCLES=4 and GUARD_CYCLES=0 instances).
module tb_spi_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, z_req0 = 1'b0, z_req1 = 1'b0;
  logic rq0_sck = 1'b0, rq0_mosi = 1'b0, rq0_csn = 1'b1;
  logic rq1_sck = 1'b0, rq1_mosi = 1'b0, rq1_csn = 1'b1;
  logic gnt0, gnt1, spi_sck, spi_mosi, flash_csn, codec_csn, busy, timeout;
  logic z_gnt0, z_gnt1, z_sck, z_mosi, z_fcs, z_ccs, z_busy, z_timeout;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  spi_bus_arbiter #(.GUARD_CYCLES(4), .SCK_IDLE(1'b0), .MAX_HOLD(16)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .rq0_sck(rq0_sck), .rq0_mosi(rq0_mosi), .rq0_csn(rq0_csn),
    .rq1_sck(rq1_sck), .rq1_mosi(rq1_mosi), .rq1_csn(rq1_csn),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .flash_csn(flash_csn), .codec_csn(codec_csn),
    .busy(busy), .timeout(timeout)
  );
  spi_bus_arbiter #(.GUARD_CYCLES(0), .SCK_IDLE(1'b0), .MAX_HOLD(16)) u_zero (
    .clk(clk), .reset(reset), .req0(z_req0), .req1(z_req1), .gnt0(z_gnt0), .gnt1(z_gnt1),
    .rq0_sck(rq0_sck), .rq0_mosi(rq0_mosi), .rq0_csn(rq0_csn),
    .rq1_sck(rq1_sck), .rq1_mosi(rq1_mosi), .rq1_csn(rq1_csn),
    .spi_sck(z_sck), .spi_mosi(z_mosi), .flash_csn(z_fcs), .codec_csn(z_ccs),
    .busy(z_busy), .timeout(z_timeout)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic release_gap(input bit who);
    int gap;
    if (who) req1 = 1'b0; else req0 = 1'b0;
    step;
    chk("rr_release_gnt", {14'd0, gnt1, gnt0}, 16'd0);
    if (who) req1 = 1'b1; else req0 = 1'b1;
    gap = 0;
    while (!(gnt0 | gnt1) && gap < 20) begin
      chk("rr_gap_cs", {14'd0, flash_csn, codec_csn}, 16'd3);
      gap++;
      step;
    end
    chk("rr_gap_len", 16'(gap), 16'd4);
    chk("rr_next_gnt", {14'd0, gnt1, gnt0}, who ? 16'd1 : 16'd2);
  endtask
  initial begin
    logic [7:0] pat;
    logic s;
    int own;
    pat = 8'hA5;
    step;
    step;
    chk("rst_gnt", {14'd0, gnt1, gnt0}, 16'd0);
    chk("rst_sck_mosi", {14'd0, spi_sck, spi_mosi}, 16'd0);
    chk("rst_cs", {14'd0, flash_csn, codec_csn}, 16'd3);
    chk("rst_busy_to", {14'd0, busy, timeout}, 16'd0);
    reset = 1'b0;
    req1 = 1'b1;
    rq1_csn = 1'b0;
    step;
    chk("gnt1_first", {14'd0, gnt1, gnt0}, 16'd2);
    chk("gnt1_busy", {15'd0, busy}, 16'd1);
    chk("gnt1_cs_grant_cycle", {14'd0, flash_csn, codec_csn}, 16'd3);
    step;
    chk("codec_cs_low", {14'd0, flash_csn, codec_csn}, 16'd2);
    rq0_csn = 1'b0;
    rq0_sck = 1'b0;
    rq1_sck = 1'b1;
    rq1_mosi = 1'b1;
    step;
    chk("nonowner_cs", {14'd0, flash_csn, codec_csn}, 16'd2);
    chk("own1_pins", {14'd0, spi_sck, spi_mosi}, 16'd3);
    reset = 1'b1;
    step;
    chk("midrst_cs", {14'd0, flash_csn, codec_csn}, 16'd3);
    chk("midrst_gnt_busy", {13'd0, gnt1, gnt0, busy}, 16'd0);
    chk("midrst_sck", {14'd0, spi_sck, spi_mosi}, 16'd0);
    reset = 1'b0;
    req1 = 1'b0;
    rq0_csn = 1'b1;
    rq1_csn = 1'b1;
    rq1_sck = 1'b0;
    rq1_mosi = 1'b0;
    step;
    req0 = 1'b1;
    rq0_csn = 1'b0;
    step;
    chk("gnt0", {14'd0, gnt1, gnt0}, 16'd1);
    s = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      s = ~s;
      rq0_sck = s;
      rq0_mosi = pat[i];
      rq1_sck = 1'($urandom);
      rq1_mosi = 1'($urandom);
      rq1_csn = 1'($urandom);
      step;
      chk("a5_mosi", {15'd0, spi_mosi}, {15'd0, pat[i]});
      chk("a5_sck", {15'd0, spi_sck}, {15'd0, s});
      chk("a5_cs", {14'd0, flash_csn, codec_csn}, 16'd1);
    end
    req0 = 1'b0;
    rq0_csn = 1'b1;
    rq1_csn = 1'b1;
    step;
    chk("rel0_gnt", {14'd0, gnt1, gnt0}, 16'd0);
    chk("rel0_pins", {12'd0, spi_sck, spi_mosi, flash_csn, codec_csn}, 16'd3);
    chk("rel0_busy", {15'd0, busy}, 16'd1);
    req1 = 1'b1;
    step;
    req1 = 1'b0;
    repeat (6) step;
    chk("dropped_req", {13'd0, gnt1, gnt0, busy}, 16'd0);
    reset = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    step;
    chk("rr_rst", {14'd0, gnt1, gnt0}, 16'd0);
    reset = 1'b0;
    step;
    chk("rr_first", {14'd0, gnt1, gnt0}, 16'd2);
    step;
    step;
    release_gap(1'b1);
    step;
    step;
    release_gap(1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (8) step;
    chk("rr_idle", {13'd0, gnt1, gnt0, busy}, 16'd0);
    z_req0 = 1'b1;
    step;
    chk("g0_gnt0", {14'd0, z_gnt1, z_gnt0}, 16'd1);
    z_req1 = 1'b1;
    step;
    chk("g0_hold", {14'd0, z_gnt1, z_gnt0}, 16'd1);
    z_req0 = 1'b0;
    step;
    chk("g0_fall", {13'd0, z_gnt1, z_gnt0, z_busy}, 16'd0);
    chk("g0_fall_cs", {14'd0, z_fcs, z_ccs}, 16'd3);
    step;
    chk("g0_rise", {14'd0, z_gnt1, z_gnt0}, 16'd2);
    z_req1 = 1'b0;
    req0 = 1'b1;
    step;
    chk("to_gnt0", {14'd0, gnt1, gnt0}, 16'd1);
`ifdef SPI_ARB_TIMEOUT_EN
    own = 0;
    while (gnt0 && own < 40) begin
      chk("to_quiet", {15'd0, timeout}, 16'd0);
      own++;
      step;
    end
    chk("to_hold_len", 16'(own), 16'd16);
    chk("to_pulse", {14'd0, gnt0, timeout}, 16'd1);
    step;
    chk("to_pulse_end", {15'd0, timeout}, 16'd0);
    repeat (10) step;
    chk("to_no_regrant", {13'd0, gnt1, gnt0, busy}, 16'd0);
    req0 = 1'b0;
    step;
    req0 = 1'b1;
    step;
    chk("to_rearm", {14'd0, gnt1, gnt0}, 16'd1);
`else
    own = 0;
    repeat (20) begin
      own += int'(gnt0);
      step;
    end
    chk("nto_hold_len", 16'(own), 16'd20);
    chk("nto_still_own", {14'd0, gnt0, timeout}, 16'd2);
`endif
    req0 = 1'b0;
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single SPI pin set (flash_clk / flash_io0 / chip selects) between two requesters: the picosoc flash engine (requester 0) and the codec configurator (requester 1).
- Replaces the static select-by-config-done mux with a request/grant handshake, so the CPU can reconfigure the codec at runtime.
- Enforces chip-select separation and a guard gap between owners.
- Sits between the SoC/configurator and the SB_IO flash pins.

Parameters:
- GUARD_CYCLES, 4, idle clk cycles with both CS high between one owner releasing and the next grant (0..255).
- SCK_IDLE, 1'b0, level driven on spi_sck when no owner.
- MAX_HOLD, 65535, clk cycles an owner may hold the bus (used only with the optional feature).

Ports:
- clk  in  1  system clock (12 MHz domain)
- reset  in  1  synchronous active-high reset
- req0  in  1  flash engine bus request
- req1  in  1  codec configurator bus request
- gnt0  out  1  grant to requester 0
- gnt1  out  1  grant to requester 1
- rq0_sck, rq0_mosi, rq0_csn  in  1 each  requester 0 SPI drive
- rq1_sck, rq1_mosi, rq1_csn  in  1 each  requester 1 SPI drive
- spi_sck  out  1  pin clock
- spi_mosi  out  1  pin data out (io0)
- flash_csn  out  1  flash chip select
- codec_csn  out  1  codec chip select
- busy  out  1  high in OWN or GUARD
- timeout  out  1  1-cycle pulse on forced revoke (optional feature; else tied 0)

Behaviour:
- All outputs registered. Reset values:
  - gnt0 = gnt1 = 0
  - spi_sck = SCK_IDLE, spi_mosi = 0
  - flash_csn = codec_csn = 1
  - busy = 0, timeout = 0
  - state IDLE, last_owner = 0
- Reset mid-transfer: the next cycle shows the reset values, regardless of request inputs.
- States: IDLE, OWN0, OWN1, GUARD.
- IDLE:
  - Only req1: go OWN1.
  - Only req0: go OWN0.
  - Both: round-robin; grant the requester that is not last_owner. After reset last_owner = 0, so the codec wins the first tie.
  - Grant asserts the cycle after req is sampled high.
- OWNn:
  - gntn = 1.
  - Each cycle, spi_sck / spi_mosi <= rqn_sck / rqn_mosi.
  - Owner's CS <= rqn_csn (OWN0 drives flash_csn, OWN1 drives codec_csn).
  - The other CS is held 1, and the other requester's SPI inputs are ignored.
  - Latency from requester input to pin: exactly 1 cycle.
  - reqn low sampled: next cycle gntn = 0, both CS = 1, spi_sck = SCK_IDLE, spi_mosi = 0; last_owner <= n; go GUARD.
  - If GUARD_CYCLES == 0, go IDLE directly.
- GUARD:
  - 8-bit counter loads GUARD_CYCLES - 1 on entry and decrements.
  - At 0, go IDLE. First possible new grant is GUARD_CYCLES + 1 cycles after the release was sampled.
  - Requests arriving during GUARD are held pending, not lost (req is level).
- Requester drops req before grant: no grant is issued and no state change.
- Non-owner asserts its rq_csn: no effect on any pin.
- Both requests asserted continuously: grants alternate 1,0,1,0…, each separated by a GUARD window.
- gnt0 and gnt1 are never high together. Both CS pins are never low together, in any cycle.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on entry to OWNn and increments each OWN cycle.
  - When it reaches MAX_HOLD, the arbiter revokes: same outputs as a normal release.
  - timeout pulses high for 1 cycle; last_owner updates; go GUARD.
  - The revoked requester must drop and re-raise req before it can be granted again (rearm flag per requester).
- Undefined: no counter, timeout tied 0, ownership unbounded.

Test Plan:
- Reset, then req1 = 1 at cycle 0 → gnt1 = 1 at cycle 1; rq1_csn = 0 → codec_csn = 0 next cycle, flash_csn stays 1.
- OWN0, toggle rq0_sck/rq0_mosi with pattern 0xA5 serially → spi_sck/spi_mosi reproduce the pattern delayed exactly 1 cycle; rq1_* toggling has no effect.
- req0 and req1 both high from reset → grant order 1,0,1. With GUARD_CYCLES = 4, exactly 4 cycles with both CS = 1 and gnt = 0 between owners.
- Assert reset while codec_csn = 0 in OWN1 → next cycle codec_csn = 1, gnt1 = 0, busy = 0, spi_sck = SCK_IDLE.
- GUARD_CYCLES = 0: req0 drops while req1 high → gnt0 falls at cycle n+1, gnt1 rises at cycle n+2.
- SPI_ARB_TIMEOUT_EN with MAX_HOLD = 16, req0 held high → after 16 OWN0 cycles gnt0 falls and timeout pulses once. gnt0 is not re-granted until req0 is dropped and re-raised.
